// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO command controller.
package fifo_pkg;

    localparam int DATA_W_DEFAULT = 15;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        CHECK        = 3'd1,
        ISSUE_WR     = 3'd2,
        ISSUE_RD     = 3'd3,
        CAPTURE      = 3'd4,
        WAIT_RELEASE = 3'd5
    } cmd_state_t;

    localparam logic MODE_WR = 1'b1;
    localparam logic MODE_RD = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer and counter debouncer for an active-low push-button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_pressed,
    output logic o_released,
    output logic o_settled
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_pressed;
    logic             r_released;
    logic [CNT_W-1:0] r_cnt;

    // Level only flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_level    <= 1'b1;
            r_cnt      <= '0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_sync1    <= i_btn_n;
            r_sync2    <= r_sync1;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level    <= r_sync2;
                    r_cnt      <= '0;
                    r_pressed  <= ~r_sync2;
                    r_released <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level    = r_level;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;
    // Settled: released level with nothing low still travelling through the synchronizer.
    assign o_settled  = r_level & r_sync1 & r_sync2;

endmodule

// File: rtl/fifo_cmd_ctrl.sv
// Turns debounced button presses into single FIFO push/pop strobes and
// captures popped words for the display.
module fifo_cmd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W          = DATA_W_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              button,
    input  logic              mode,
    input  logic [DATA_W-1:0] datain,
    input  logic              full,
    input  logic              empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              err_full,
    output logic              err_empty,
    output logic              busy
);

    logic w_level;
    logic w_pressed;
    logic w_released;
    logic w_settled;
    logic w_release_ok;

    cmd_state_t        r_state;
    logic              r_mode;
    logic [DATA_W-1:0] r_cmd_data;
    logic              r_wr_en;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_rd_en;
    logic [DATA_W-1:0] r_disp_data;
    logic              r_disp_valid;
    logic              r_err_full;
    logic              r_err_empty;
    logic              r_guard;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .i_btn_n   (button),
        .o_level   (w_level),
        .o_pressed (w_pressed),
        .o_released(w_released),
        .o_settled (w_settled)
    );

    // r_guard holds WAIT_RELEASE for the first cycle after reset so a button
    // held through reset reaches the synchronizer before release is judged.
    assign w_release_ok = r_guard & w_level & (w_released | w_settled);

    // Command FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= WAIT_RELEASE;
            r_mode       <= MODE_RD;
            r_cmd_data   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_data    <= '0;
            r_rd_en      <= 1'b0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_err_full   <= 1'b0;
            r_err_empty  <= 1'b0;
            r_guard      <= 1'b0;
        end else begin
            r_guard <= 1'b1;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pressed) begin
                        r_mode     <= mode;
                        r_cmd_data <= datain;
                        r_state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (r_mode == MODE_WR) begin
                        if (!full) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= r_cmd_data;
                            r_state   <= ISSUE_WR;
                        end else begin
                            r_err_full  <= 1'b1;
                            r_err_empty <= 1'b0;
                            r_state     <= WAIT_RELEASE;
                        end
                    end else begin
                        if (!empty) begin
                            r_rd_en <= 1'b1;
                            r_state <= ISSUE_RD;
                        end else begin
                            r_err_empty <= 1'b1;
                            r_err_full  <= 1'b0;
                            r_state     <= WAIT_RELEASE;
                        end
                    end
                end
                ISSUE_WR: begin
                    r_err_full  <= 1'b0;
                    r_err_empty <= 1'b0;
                    r_state     <= WAIT_RELEASE;
                end
                ISSUE_RD: begin
                    r_err_full  <= 1'b0;
                    r_err_empty <= 1'b0;
                    r_state     <= CAPTURE;
                end
                CAPTURE: begin
                    r_disp_data  <= rd_data;
                    r_disp_valid <= 1'b1;
                    r_state      <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (w_release_ok) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= WAIT_RELEASE;
                end
            endcase
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_data    = r_wr_data;
    assign rd_en      = r_rd_en;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign err_full   = r_err_full;
    assign err_empty  = r_err_empty;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_cmd_ctrl.sv
// Self-checking bench for fifo_cmd_ctrl: vector table plus strobe scoreboard.
module tb_fifo_cmd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        button;
    logic        mode;
    logic [14:0] datain;
    logic        full;
    logic        empty;
    logic [14:0] rd_data;
    logic        wr_en;
    logic [14:0] wr_data;
    logic        rd_en;
    logic [14:0] disp_data;
    logic        disp_valid;
    logic        err_full;
    logic        err_empty;
    logic        busy;

    logic [14:0] rd_val;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        bit          is_wr;
        logic [14:0] d;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        m;
        logic [14:0] d;
        logic        full;
        logic        empty;
        logic [14:0] rdv;
        int          kind;
        logic        ef;
        logic        ee;
    } vec_t;
    vec_t vecs[8];

    bit          disp_pend = 1'b0;
    int          disp_cyc = 0;
    logic [14:0] disp_exp = '0;
    logic [14:0] exp_disp;
    logic        exp_dv;

    fifo_cmd_ctrl #(
        .DATA_W         (15),
        .DEBOUNCE_CYCLES(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .button    (button),
        .mode      (mode),
        .datain    (datain),
        .full      (full),
        .empty     (empty),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .disp_data (disp_data),
        .disp_valid(disp_valid),
        .err_full  (err_full),
        .err_empty (err_empty),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO read-port model: data valid only in the cycle after rd_en.
    always @(posedge clk) rd_data <= rd_en ? rd_val : 15'h2AAA;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (disp_pend && cyc == disp_cyc) begin
            disp_pend = 1'b0;
            chk("disp_data_2edge", 32'(disp_data), 32'(disp_exp));
            chk("disp_valid_2edge", 32'(disp_valid), 32'd1);
        end
        if (wr_en || rd_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe wr_en=%0b rd_en=%0b expected none (cycle %0d)",
                         wr_en, rd_en, cyc);
            end else begin
                e = sb.pop_front();
                chk("strobe_kind", 32'({wr_en, rd_en}), e.is_wr ? 32'd2 : 32'd1);
                if (e.is_wr) chk("wr_data", 32'(wr_data), 32'(e.d));
                if (e.cyc >= 0) chk("strobe_latency", 32'(cyc), 32'(e.cyc));
                if (!e.is_wr) begin
                    disp_pend = 1'b1;
                    disp_cyc  = cyc + 2;
                    disp_exp  = e.d;
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    // kind: 0 = no strobe expected, 1 = write, 2 = read
    task automatic press(input logic m, input logic [14:0] d, input int hold, input int kind);
        @(negedge clk);
        mode   = m;
        datain = d;
        button = 1'b0;
        if (kind == 1) sb.push_back('{1'b1, d, cyc + 7});
        else if (kind == 2) sb.push_back('{1'b0, rd_val, cyc + 7});
        repeat (hold) @(negedge clk);
        button = 1'b1;
        wait_idle("idle_after_press");
    endtask

    initial begin
        int n;
        vecs[0] = '{m:1'b1, d:15'd32000, full:1'b0, empty:1'b0, rdv:15'd0,     kind:1, ef:1'b0, ee:1'b0};
        vecs[1] = '{m:1'b0, d:15'd0,     full:1'b0, empty:1'b0, rdv:15'd25000, kind:2, ef:1'b0, ee:1'b0};
        vecs[2] = '{m:1'b1, d:15'd77,    full:1'b1, empty:1'b0, rdv:15'd0,     kind:0, ef:1'b1, ee:1'b0};
        vecs[3] = '{m:1'b0, d:15'd0,     full:1'b0, empty:1'b1, rdv:15'd11,    kind:0, ef:1'b0, ee:1'b1};
        vecs[4] = '{m:1'b1, d:15'd1234,  full:1'b0, empty:1'b1, rdv:15'd0,     kind:1, ef:1'b0, ee:1'b0};
        vecs[5] = '{m:1'b1, d:15'd5,     full:1'b1, empty:1'b0, rdv:15'd0,     kind:0, ef:1'b1, ee:1'b0};
        vecs[6] = '{m:1'b0, d:15'd0,     full:1'b1, empty:1'b0, rdv:15'd7,     kind:2, ef:1'b0, ee:1'b0};
        vecs[7] = '{m:1'b1, d:15'd32767, full:1'b0, empty:1'b0, rdv:15'd0,     kind:1, ef:1'b0, ee:1'b0};

        reset  = 1'b1;
        button = 1'b1;
        mode   = 1'b0;
        datain = '0;
        full   = 1'b0;
        empty  = 1'b1;
        rd_val = '0;
        exp_disp = '0;
        exp_dv   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_disp_data", 32'(disp_data), 32'd0);
        chk("rst_disp_valid", 32'(disp_valid), 32'd0);
        chk("rst_err_full", 32'(err_full), 32'd0);
        chk("rst_err_empty", 32'(err_empty), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        wait_idle("idle_after_reset");

        for (int i = 0; i < 8; i++) begin
            full   = vecs[i].full;
            empty  = vecs[i].empty;
            rd_val = vecs[i].rdv;
            press(vecs[i].m, vecs[i].d, 12, vecs[i].kind);
            if (vecs[i].kind == 2) begin
                exp_disp = vecs[i].rdv;
                exp_dv   = 1'b1;
            end
            chk("vec_err_full", 32'(err_full), 32'(vecs[i].ef));
            chk("vec_err_empty", 32'(err_empty), 32'(vecs[i].ee));
            chk("vec_disp_data", 32'(disp_data), 32'(exp_disp));
            chk("vec_disp_valid", 32'(disp_valid), 32'(exp_dv));
        end
        full  = 1'b0;
        empty = 1'b0;

        // Bounce every cycle, then a solid hold: one write.
        @(negedge clk);
        mode   = 1'b1;
        datain = 15'd555;
        for (int i = 0; i < 10; i++) begin
            button = (i % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        button = 1'b0;
        sb.push_back('{1'b1, 15'd555, -1});
        repeat (15) @(negedge clk);
        button = 1'b1;
        wait_idle("idle_after_bounce");
        chk("bounce_sb_empty", 32'(sb.size()), 32'd0);

        // Short glitches never get through.
        button = 1'b0;
        @(negedge clk);
        button = 1'b1;
        repeat (6) @(negedge clk);
        button = 1'b0;
        repeat (2) @(negedge clk);
        button = 1'b1;
        repeat (10) @(negedge clk);
        chk("glitch_busy", 32'(busy), 32'd0);

        // Long hold with mode/data changes after acceptance.
        @(negedge clk);
        mode   = 1'b1;
        datain = 15'd100;
        button = 1'b0;
        sb.push_back('{1'b1, 15'd100, cyc + 7});
        repeat (10) @(negedge clk);
        mode   = 1'b0;
        datain = 15'd10250;
        repeat (40) @(negedge clk);
        button = 1'b1;
        wait_idle("idle_after_hold");
        chk("hold_sb_empty", 32'(sb.size()), 32'd0);

        // Reset during ISSUE_RD with the button held through reset.
        @(negedge clk);
        mode   = 1'b0;
        rd_val = 15'd4321;
        button = 1'b0;
        sb.push_back('{1'b0, 15'd4321, cyc + 7});
        n = 0;
        while (!rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_rd_en_seen", 32'(rd_en), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        disp_pend = 1'b0;
        @(negedge clk);
        chk("midrst_rd_en", 32'(rd_en), 32'd0);
        chk("midrst_wr_data", 32'(wr_data), 32'd0);
        chk("midrst_disp_data", 32'(disp_data), 32'd0);
        chk("midrst_disp_valid", 32'(disp_valid), 32'd0);
        chk("midrst_err_full", 32'(err_full), 32'd0);
        chk("midrst_err_empty", 32'(err_empty), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        chk("held_through_reset_busy", 32'(busy), 32'd1);
        button = 1'b1;
        wait_idle("idle_after_reset_release");
        rd_val = 15'd999;
        press(1'b0, 15'd0, 12, 2);
        chk("repress_disp_data", 32'(disp_data), 32'd999);
        chk("repress_disp_valid", 32'(disp_valid), 32'd1);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_cmd_ctrl.md
# fifo_cmd_ctrl

Command controller sitting between the board's raw user inputs (push-button, mode switch, 15-bit data switches) and the FIFO core. Synchronizes and debounces the active-low button, turns each debounced press into exactly one single-cycle write or read strobe depending on `mode`, and blocks illegal operations on full/empty. Captures popped words into a display register that drives the 7-segment decoders, and flags rejected commands.

## Interface
Parameters:
- `DATA_W`, 15: data word width.
- `DEBOUNCE_CYCLES`, 3: consecutive identical synchronized samples required to accept a button level change; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `button`  in  1  raw push-button, active-low (0 = pressed), asynchronous to `clk`.
- `mode`  in  1  1 = write (push), 0 = read (pop); sampled at press acceptance.
- `datain`  in  DATA_W  switch data; sampled at press acceptance.
- `full`  in  1  FIFO full flag.
- `empty`  in  1  FIFO empty flag.
- `rd_data`  in  DATA_W  FIFO read port, valid the cycle after `rd_en`.
- `wr_en`  out  1  one-cycle push strobe.
- `wr_data`  out  DATA_W  data accompanying `wr_en`.
- `rd_en`  out  1  one-cycle pop strobe.
- `disp_data`  out  DATA_W  last popped word, held until the next successful pop.
- `disp_valid`  out  1  high once any word has been popped since reset.
- `err_full`  out  1  sticky: last command was a write rejected on full; cleared by the next accepted command.
- `err_empty`  out  1  sticky: last command was a read rejected on empty; cleared likewise.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset values: `wr_en`=0, `rd_en`=0, `wr_data`=0, `disp_data`=0, `disp_valid`=0, `err_full`=0, `err_empty`=0; synchronizer flops=1 (released); debounce counter=0; debounced level=1; state=WAIT_RELEASE.
- Input path: `button` → 2-flop synchronizer → debouncer. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive synchronized samples differing from it; any bounce resets the counter.
- FSM states:
  - IDLE: on the debounced falling edge (press), latch `mode` and `datain` → CHECK.
  - CHECK: write & !`full` → ISSUE_WR; write & `full` → set `err_full`, clear `err_empty`, → WAIT_RELEASE; read & !`empty` → ISSUE_RD; read & `empty` → set `err_empty`, clear `err_full`, → WAIT_RELEASE.
  - ISSUE_WR: `wr_en`=1 with `wr_data`=latched data for exactly this cycle; clear both err flags → WAIT_RELEASE.
  - ISSUE_RD: `rd_en`=1 for exactly this cycle; clear both err flags → CAPTURE.
  - CAPTURE: `disp_data`←`rd_data`, `disp_valid`←1 → WAIT_RELEASE.
  - WAIT_RELEASE: wait for debounced level = 1 → IDLE.
- Exactly one strobe per press regardless of hold time; a held button never auto-repeats.
- `mode`/`datain` changes after acceptance do not affect the in-flight command.
- `full`/`empty` are evaluated only in CHECK; flag changes in other states are ignored.
- Reset mid-command (any state): outputs go to their reset values next edge; a strobe in flight is dropped. Because reset enters WAIT_RELEASE, a button held through reset issues nothing until released and pressed again.

## Timing
- Clock edge k first samples `button`=0 with stable input: the debounced level falls at edge k+1+`DEBOUNCE_CYCLES`; CHECK is entered at the following edge; `wr_en`/`rd_en` are high during the cycle after CHECK. Total press-to-strobe = `DEBOUNCE_CYCLES`+4 edges (7 for the default).
- `disp_data` updates on the edge ending CAPTURE, i.e., 2 edges after `rd_en` rises.
- Release to IDLE: `DEBOUNCE_CYCLES`+2 edges after the first released sample.
- Minimum press-to-press spacing: one full press/release cycle; presses during WAIT_RELEASE are impossible by construction.

## Structure
- `fifo_pkg`: `DATA_W` default constant, `cmd_state_t` enum (IDLE, CHECK, ISSUE_WR, ISSUE_RD, CAPTURE, WAIT_RELEASE), and the mode encoding constants `MODE_WR`=1, `MODE_RD`=0.
- Sub-module `btn_debounce` (synchronizer, counter of width $clog2(`DEBOUNCE_CYCLES`+1), debounced level, one-cycle `pressed`/`released` pulses); the FSM and datapath registers stay in `fifo_cmd_ctrl`.

## Test plan
- Write: `mode`=1, `datain`=32000, press held 12 cycles, `full`=0 → a single `wr_en` pulse 7 edges after the press with `wr_data`=32000; no `rd_en`.
- Read: `rd_data` model returns 25000 after `rd_en`; `mode`=0, press → one `rd_en`, `disp_data`=25000 and `disp_valid`=1 two edges later, held after release.
- Bounce: toggle `button` 0/1 every cycle for 10 cycles, then hold 0 → exactly one strobe; isolated glitches shorter than 3 cycles → none.
- Reject: `full`=1, write press → `err_full`=1, no `wr_en`; `empty`=1, read press → `err_empty`=1, `err_full`=0, no `rd_en`; next accepted write clears both.
- Hold and mode change: press with `mode`=1, `datain`=100, flip `mode` to 0 and `datain` to 10250 while held 50 cycles → one `wr_en` with data 100, nothing else.
- Reset: assert `reset` during ISSUE_RD → `rd_en`=0 next edge, all outputs at reset values; button held through reset → no strobe until release and re-press.
